bf16_result_buffer: RTL
=======================

Name: bf16_result_buffer

Overview:
- Downstream stage of bf16_minmax (and other BF16 execution units): captures each valid result, its fpcsr flags and its operation code into a small first-word-fall-through FIFO.
- Presents entries to the host/writeback side with a valid/ready handshake.
- Keeps OR-accumulated sticky fpcsr flags and a sticky overflow flag for dropped results.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_W, 16, result width (BF16).
- FLAG_W, 4, fpcsr width.
- OP_W, 4, operation-code width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream unit presents a result this cycle.
- in_ready  output  1  buffer can accept; equals (count < DEPTH).
- in_result  input  DATA_W  BF16 result from upstream unit.
- in_fpcsr  input  FLAG_W  fpcsr flags accompanying in_result.
- in_op  input  OP_W  operation code that produced the result (e.g. 4'b0010 min, 4'b0011 max).
- out_valid  output  1  head entry available; equals (count != 0).
- out_ready  input  1  consumer takes head entry this cycle.
- out_result  output  DATA_W  head entry result; 0 when empty.
- out_fpcsr  output  FLAG_W  head entry flags; 0 when empty.
- out_op  output  OP_W  head entry operation code; 0 when empty.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- sticky_fpcsr  output  FLAG_W  OR of fpcsr of all accepted entries since last clear.
- overflow  output  1  sticky; set when a result was offered while full.
- clear_sticky  input  1  synchronous clear of sticky_fpcsr and overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, sticky_fpcsr=0, overflow=0.
  - Outputs follow: out_valid=0, out_result/out_fpcsr/out_op=0, in_ready=1.
  - Inputs are ignored while reset is low.
  - Reset mid-operation discards all stored entries; no partial state survives.
- push = in_valid & in_ready. Writes {in_result, in_fpcsr, in_op} at wr_ptr; wr_ptr increments modulo DEPTH.
- pop = out_valid & out_ready. rd_ptr increments modulo DEPTH.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Latency: an entry pushed in cycle N appears on out_* in cycle N+1 (first-word-fall-through, registered storage, combinational head read).
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Full (count==DEPTH):
  - in_ready=0, so no push, even if a pop occurs in the same cycle (no pass-through).
  - in_valid=1 while full sets overflow=1 at the next edge; the offered result is dropped.
- Empty (count==0):
  - out_valid=0 and out_* forced to 0.
  - out_ready is ignored; no pointer underflow.
  - No bypass: a push into an empty buffer is not visible on out_* in the same cycle.
- Sticky flags:
  - sticky_fpcsr_next = (clear_sticky ? 0 : sticky_fpcsr) | (push ? in_fpcsr : 0). Flags of a result accepted in the clear cycle survive the clear.
  - overflow_next = (clear_sticky ? 0 : overflow) | (in_valid & ~in_ready). Set wins over a simultaneous clear.
  - Dropped results do not contribute to sticky_fpcsr.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count only.
- Control is a counter-based FIFO; occupancy is classified as EMPTY (0), PARTIAL (1..DEPTH-1) or FULL (DEPTH), with transitions driven only by push/pop as above.

Test Plan:
1. After reset release, push {16'h3C00, 4'h0, 4'b0010} with out_ready=0 -> next cycle out_valid=1, out_result=16'h3C00, out_op=4'b0010, count=1, in_ready=1.
2. Push 16'h4000, 16'h7FC0 (fpcsr 4'h1), 16'h3555, 16'h7F80 with out_ready=0 -> count=4, in_ready=0, sticky_fpcsr=4'h1. Offer 16'h0080 -> overflow=1, count stays 4. Drain with out_ready=1 -> outputs 16'h4000, 16'h7FC0, 16'h3555, 16'h7F80 in order, then out_valid=0, out_result=0.
3. At count=2, hold in_valid=1 and out_ready=1 for 6 cycles with results 16'h0001..16'h0006 -> count stays 2, outputs in push order, pointers wrap past DEPTH without loss.
4. Full buffer, in_valid=1 and out_ready=1 in the same cycle -> pop occurs, push refused, overflow=1, count=3.
5. sticky_fpcsr=4'h1 and clear_sticky=1 in the same cycle as a push with in_fpcsr=4'h4 -> sticky_fpcsr=4'h4. clear_sticky alone with no push -> sticky_fpcsr=0, overflow=0.
6. Assert reset=0 asynchronously mid-cycle with count=3 -> out_valid, count, sticky_fpcsr and overflow go to 0 immediately, without waiting for a clock edge; after release the first push is the first output.

Source files
------------

// File: rtl/bf16_result_buffer.sv
// First-word-fall-through result FIFO behind the BF16 execution units.
// Stores {result, fpcsr, op}, presents the head via valid/ready, and keeps sticky flags.
module bf16_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int FLAG_W = 4,
  parameter int OP_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [FLAG_W-1:0]          in_fpcsr,
  input  logic [OP_W-1:0]            in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_result,
  output logic [FLAG_W-1:0]          out_fpcsr,
  output logic [OP_W-1:0]            out_op,
  output logic [$clog2(DEPTH):0]     count,
  output logic [FLAG_W-1:0]          sticky_fpcsr,
  output logic                       overflow,
  input  logic                       clear_sticky
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + FLAG_W + OP_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_e;

  occ_e                state_q, state_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [FLAG_W-1:0]   sticky_q, sticky_d;
  logic                overflow_q, overflow_d;
  logic                push, pop;
  logic [ENTRY_W-1:0]  head;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];

  // Occupancy classification mirrors count so handshakes come straight from a register.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    sticky_d   = (clear_sticky ? '0 : sticky_q) | (push ? in_fpcsr : '0);
    overflow_d = (clear_sticky ? 1'b0 : overflow_q) | (in_valid & ~in_ready);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (count_d == '0)
      state_d = EMPTY;
    else if (count_d == FULL_CNT)
      state_d = FULL;
    else
      state_d = PARTIAL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sticky_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wr_ptr_q] <= {in_result, in_fpcsr, in_op};
    end
  end

  // Empty buffer presents zeros rather than stale storage.
  always_comb begin
    out_result = '0;
    out_fpcsr  = '0;
    out_op     = '0;
    if (out_valid) begin
      out_result = head[ENTRY_W-1 -: DATA_W];
      out_fpcsr  = head[OP_W +: FLAG_W];
      out_op     = head[OP_W-1:0];
    end
  end

  assign count        = count_q;
  assign sticky_fpcsr = sticky_q;
  assign overflow     = overflow_q;

endmodule
